// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the LCD master and the on-chip target receiver.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAckAddr,
    StData,
    StAckData,
    StIgnore
  } i2c_rx_state_t;

  localparam logic       I2C_RW_WRITE = 1'b0;
  localparam logic [6:0] I2C_ADDR_LCD = 7'h27;

endpackage

// File: rtl/i2c_sync_edge.sv
// N-stage synchronizer for an asynchronous bus pin with registered-history edge detect.
module i2c_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   fill_q;

  // Idle bus level is high; edges stay masked until the chain holds real pin samples,
  // so a low pin at reset release cannot look like a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = fill_q[STAGES] & q & ~prev_q;
  assign fall = fill_q[STAGES] & ~q & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: detects START/STOP, matches the address, ACKs and strobes out data bytes.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = I2C_ADDR_LCD,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       addr_match,
  output logic       stop_det,
  output logic       bus_busy
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (scl_in),
    .q    (scl_s),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sda_in),
    .q    (sda_s),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  i2c_rx_state_t state_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          first_q;
  logic          start_ev, stop_ev;
  logic [7:0]    shift_next;

  // SCL must be stably high: an SCL edge in the same sync cycle makes it a data transition.
  assign start_ev   = sda_fall & scl_s & ~scl_rise;
  assign stop_ev    = sda_rise & scl_s & ~scl_rise;
  assign shift_next = {shift_q[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      first_q    <= 1'b0;
      sda_oe     <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      addr_match <= 1'b0;
      stop_det   <= 1'b0;
      bus_busy   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      stop_det <= 1'b0;
      if (stop_ev) begin
        state_q    <= StIdle;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
        bus_busy   <= 1'b0;
        stop_det   <= 1'b1;
      end else if (start_ev) begin
        state_q    <= StAddr;
        bit_cnt_q  <= 4'd0;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
        bus_busy   <= 1'b1;
        first_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StAddr, StData: begin
            if (scl_rise) begin
              shift_q   <= shift_next;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                if (state_q == StAddr) begin
                  state_q <= (shift_q[6:0] == TARGET_ADDR && sda_s == I2C_RW_WRITE) ?
                             StAckAddr : StIgnore;
                end else begin
                  rx_data  <= shift_next;
                  rx_valid <= 1'b1;
                  rx_first <= first_q;
                  first_q  <= 1'b0;
                  state_q  <= StAckData;
                end
              end
            end
          end
          // sda_oe doubles as the ACK phase: first fall drives, second fall releases.
          StAckAddr, StAckData: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe     <= 1'b1;
                addr_match <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                state_q <= StData;
                if (state_q == StAckAddr) first_q <= 1'b1;
              end
            end
          end
          StIgnore: sda_oe <= 1'b0;
          default:  state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
